// File: rtl/seq_mult_pkg.sv
// rtl/seq_mult_pkg.sv - shared state encoding and sizing helper for the sequential multiplier
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit counter must index 0..width-1; keep at least one bit for width 2.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/seq_mult_datapath.sv
// rtl/seq_mult_datapath.sv - operand magnitudes, shift-add accumulator, bit counter and sign-fixed product
module seq_mult_datapath
    import seq_mult_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int SIGNED_EN = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    input  logic                 finish,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic [WIDTH-1:0]     multiplicand,
    output logic                 last,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = cnt_width(WIDTH);
    localparam int PW = 2 * WIDTH;

    logic [WIDTH-1:0] mplier;
    logic [PW-1:0]    mcand;
    logic [PW-1:0]    acc;
    logic [CW-1:0]    cnt;
    logic             neg;

    logic             signed_mode;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    // The most-negative operand negates to itself, which is its correct unsigned magnitude.
    assign signed_mode = (SIGNED_EN != 0) && is_signed;
    assign mag_a = (signed_mode && multiplier[WIDTH-1])   ? ((~multiplier) + WIDTH'(1))   : multiplier;
    assign mag_b = (signed_mode && multiplicand[WIDTH-1]) ? ((~multiplicand) + WIDTH'(1)) : multiplicand;

    assign last = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mplier  <= '0;
            mcand   <= '0;
            acc     <= '0;
            cnt     <= '0;
            neg     <= 1'b0;
            product <= '0;
        end else begin
            if (load) begin
                mplier <= mag_a;
                mcand  <= {{WIDTH{1'b0}}, mag_b};
                acc    <= '0;
                cnt    <= '0;
                neg    <= signed_mode && (multiplier[WIDTH-1] ^ multiplicand[WIDTH-1]);
            end else if (step) begin
                // Multiplicand shifts left as the multiplier shifts right: bit cnt sees mcand << cnt.
                if (mplier[0]) begin
                    acc <= acc + mcand;
                end
                mplier <= mplier >> 1;
                mcand  <= mcand << 1;
                cnt    <= cnt + CW'(1);
            end
            if (finish) begin
                product <= neg ? ((~acc) + PW'(1)) : acc;
            end
        end
    end

endmodule

// File: rtl/seq_multiplier_n.sv
// rtl/seq_multiplier_n.sv - start/busy/done control FSM around the shift-add multiplier datapath
module seq_multiplier_n
    import seq_mult_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int SIGNED_EN = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic [WIDTH-1:0]     multiplicand,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    state_t state;
    logic   load;
    logic   step;
    logic   finish;
    logic   last;

    assign load   = (state == IDLE) && start;
    assign step   = (state == CALC);
    assign finish = (state == DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= CALC;
                        busy  <= 1'b1;
                    end
                end
                CALC: begin
                    if (last) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    // Product register loads on this same edge, so done and the new product align.
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    seq_mult_datapath #(
        .WIDTH     (WIDTH),
        .SIGNED_EN (SIGNED_EN)
    ) u_datapath (
        .clk          (clk),
        .rst          (rst),
        .load         (load),
        .step         (step),
        .finish       (finish),
        .is_signed    (is_signed),
        .multiplier   (multiplier),
        .multiplicand (multiplicand),
        .last         (last),
        .product      (product)
    );

endmodule

// File: tb/tb_seq_multiplier_n.sv
// tb/tb_seq_multiplier_n.sv - self-checking bench for seq_multiplier_n (8-bit signed/unsigned and 4-bit instances)
module tb_seq_multiplier_n;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        sg = 1'b0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        busy_s, done_s, busy_u, done_u;
    logic [15:0] product_s, product_u;

    logic        start4 = 1'b0;
    logic        sg4 = 1'b0;
    logic [3:0]  a4 = '0;
    logic [3:0]  b4 = '0;
    logic        busy4, done4;
    logic [7:0]  product4;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    seq_multiplier_n #(.WIDTH(8), .SIGNED_EN(1)) dut_s (
        .clk(clk), .rst(rst), .start(start), .is_signed(sg),
        .multiplier(a8), .multiplicand(b8),
        .busy(busy_s), .done(done_s), .product(product_s)
    );

    seq_multiplier_n #(.WIDTH(8), .SIGNED_EN(0)) dut_u (
        .clk(clk), .rst(rst), .start(start), .is_signed(sg),
        .multiplier(a8), .multiplicand(b8),
        .busy(busy_u), .done(done_u), .product(product_u)
    );

    seq_multiplier_n #(.WIDTH(4), .SIGNED_EN(1)) dut_4 (
        .clk(clk), .rst(rst), .start(start4), .is_signed(sg4),
        .multiplier(a4), .multiplicand(b4),
        .busy(busy4), .done(done4), .product(product4)
    );

    function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic s);
        int p;
        if (s) p = int'($signed(a)) * int'($signed(b));
        else   p = int'(a) * int'(b);
        return p[15:0];
    endfunction

    function automatic logic [7:0] ref4(input logic [3:0] a, input logic [3:0] b, input logic s);
        int p;
        if (s) p = int'($signed(a)) * int'($signed(b));
        else   p = int'(a) * int'(b);
        return p[7:0];
    endfunction

    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic s, input string name);
        int k;
        int busy_cnt;
        bit got;
        logic [15:0] exp_s, exp_u;
        exp_s = ref8(a, b, s);
        exp_u = ref8(a, b, 1'b0);
        @(negedge clk);
        a8 = a; b8 = b; sg = s; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); sg = 1'($urandom);
        k = 0; busy_cnt = 0; got = 0;
        while (!got && k < 30) begin
            @(negedge clk);
            k++;
            if (busy_s) busy_cnt++;
            if (busy_s && done_s) begin
                tests_failed++;
                $display("FAIL %s busy_and_done: both high at cycle %0d", name, k);
            end
            if (done_s) got = 1;
        end
        tests_run++;
        if (!got) begin
            tests_failed++;
            $display("FAIL %s timeout: done not seen within 30 cycles", name);
            return;
        end
        tests_run++;
        if (k !== 10) begin
            tests_failed++;
            $display("FAIL %s done_latency: got cycle %0d, expected 10", name, k);
        end
        tests_run++;
        if (busy_cnt !== 9) begin
            tests_failed++;
            $display("FAIL %s busy_cycles: got %0d, expected 9", name, busy_cnt);
        end
        tests_run++;
        if (product_s !== exp_s) begin
            tests_failed++;
            $display("FAIL %s product_signed_inst: got %h, expected %h", name, product_s, exp_s);
        end
        tests_run++;
        if (done_u !== 1'b1 || product_u !== exp_u) begin
            tests_failed++;
            $display("FAIL %s product_unsigned_inst: done=%b got %h, expected done=1 %h", name, done_u, product_u, exp_u);
        end
        @(negedge clk);
        tests_run++;
        if (done_s !== 1'b0 || busy_s !== 1'b0 || product_s !== exp_s) begin
            tests_failed++;
            $display("FAIL %s after_done: done=%b busy=%b product=%h, expected 0 0 %h", name, done_s, busy_s, product_s, exp_s);
        end
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic s, input string name);
        int k;
        int busy_cnt;
        bit got;
        logic [7:0] exp;
        exp = ref4(a, b, s);
        @(negedge clk);
        a4 = a; b4 = b; sg4 = s; start4 = 1'b1;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        a4 = 4'($urandom); b4 = 4'($urandom);
        k = 0; busy_cnt = 0; got = 0;
        while (!got && k < 20) begin
            @(negedge clk);
            k++;
            if (busy4) busy_cnt++;
            if (done4) got = 1;
        end
        tests_run++;
        if (!got) begin
            tests_failed++;
            $display("FAIL %s timeout: done not seen within 20 cycles", name);
            return;
        end
        tests_run++;
        if (k !== 6 || busy_cnt !== 5) begin
            tests_failed++;
            $display("FAIL %s w4_latency: done cycle %0d busy %0d, expected 6 and 5", name, k, busy_cnt);
        end
        tests_run++;
        if (product4 !== exp) begin
            tests_failed++;
            $display("FAIL %s w4_product: got %h, expected %h", name, product4, exp);
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (busy_s !== 1'b0 || done_s !== 1'b0 || product_s !== 16'h0 ||
            busy_u !== 1'b0 || done_u !== 1'b0 || product_u !== 16'h0 ||
            busy4 !== 1'b0 || done4 !== 1'b0 || product4 !== 8'h0) begin
            tests_failed++;
            $display("FAIL reset_state: busy=%b done=%b product=%h busy4=%b done4=%b product4=%h, expected all zero",
                     busy_s, done_s, product_s, busy4, done4, product4);
        end
        rst = 1'b1;
    endtask

    task automatic test_directed();
        do_op(8'd255, 8'd255, 1'b0, "u_255x255");
        do_op(8'hFD,  8'd5,   1'b1, "s_m3x5");
        do_op(8'h80,  8'h80,  1'b1, "s_m128xm128");
        do_op(8'h80,  8'h80,  1'b0, "u_128x128");
        do_op(8'h00,  8'h7F,  1'b1, "s_zero");
        do_op(8'h7F,  8'h80,  1'b1, "s_max_min");
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            do_op(8'($urandom), 8'($urandom), 1'($urandom), "random");
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  opa [0:29];
        logic [7:0]  opb [0:29];
        logic        ops [0:29];
        logic [15:0] held;
        bit          have_held;
        int          ndone;
        int          e;
        have_held = 0; ndone = 0; held = '0;
        for (int c = 0; c <= 30; c++) begin
            @(negedge clk);
            if (c > 0) begin
                e = c - 1;
                if (busy_s && done_s) begin
                    tests_failed++;
                    $display("FAIL b2b busy_and_done: both high after edge %0d", e);
                end
                if (done_s) begin
                    ndone++;
                    tests_run++;
                    if (e % 10 != 9) begin
                        tests_failed++;
                        $display("FAIL b2b done_edge: done after edge %0d, expected edge 9/19/29", e);
                    end else begin
                        tests_run++;
                        if (product_s !== ref8(opa[e-9], opb[e-9], ops[e-9]) ||
                            product_u !== ref8(opa[e-9], opb[e-9], 1'b0)) begin
                            tests_failed++;
                            $display("FAIL b2b product: got %h/%h, expected %h/%h", product_s, product_u,
                                     ref8(opa[e-9], opb[e-9], ops[e-9]), ref8(opa[e-9], opb[e-9], 1'b0));
                        end
                    end
                    held = product_s;
                    have_held = 1;
                end else if (have_held) begin
                    tests_run++;
                    if (product_s !== held) begin
                        tests_failed++;
                        $display("FAIL b2b product_hold: got %h, expected %h after edge %0d", product_s, held, e);
                    end
                end
            end
            if (c < 30) begin
                opa[c] = 8'($urandom); opb[c] = 8'($urandom); ops[c] = 1'($urandom);
                a8 = opa[c]; b8 = opb[c]; sg = ops[c]; start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        tests_run++;
        if (ndone !== 3) begin
            tests_failed++;
            $display("FAIL b2b done_count: got %0d, expected 3", ndone);
        end
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        do_op(8'd200, 8'd3, 1'b0, "pre_reset");
        @(negedge clk);
        a8 = 8'd11; b8 = 8'd13; sg = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        tests_run++;
        if (busy_s !== 1'b0 || done_s !== 1'b0 || product_s !== 16'h0 || product_u !== 16'h0) begin
            tests_failed++;
            $display("FAIL async_reset: busy=%b done=%b product=%h/%h, expected 0 0 0000/0000",
                     busy_s, done_s, product_s, product_u);
        end
        @(negedge clk);
        rst = 1'b1;
        do_op(8'd7, 8'd6, 1'b0, "post_reset");
    endtask

    task automatic test_width4();
        op4(4'd0, 4'd15, 1'b0, "w4_zero");
        op4(4'h8, 4'h8,  1'b1, "w4_m8xm8");
        op4(4'h8, 4'h7,  1'b1, "w4_m8x7");
        op4(4'hF, 4'hF,  1'b0, "w4_15x15");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_width4();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
